pipe_ctrl: RTL and testbench

- Central stall controller for the 5-stage MIPS16 pipeline (pc, if_id, id_ex, ex_mem, mem_wb).
- Arbitrates the single shared SRAM between instruction fetch (IF) and data access (MEM), and sequences its wait states.
- Merges the SRAM schedule with the ID load-use request into one stall vector that drives every pipeline register's `stall` input.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_if.sv | 21 ++
 rtl/pipe_ctrl_sram_arb_fsm.sv | 96 +++++++++
 rtl/pipe_ctrl.sv | 68 ++++++
 tb/tb_pipe_ctrl.sv | 127 ++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall bit positions,
// stall patterns and SRAM arbiter state encodings.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic StallYes = 1'b1;
  localparam logic StallNo  = 1'b0;

  localparam logic [4:0] StallNone    = 5'b00000;
  localparam logic [4:0] StallIf      = 5'b00001;
  localparam logic [4:0] StallId      = 5'b00011;
  localparam logic [4:0] StallMemWait = 5'b01111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side bundle of the stall controller. master = pipeline stages,
// slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic        mem_req;
  logic        stallreq_id;
  logic [4:0]  stall;
  logic        grant_mem;
  logic        if_done;
  logic        mem_done;
  logic [15:0] stall_cnt;

  modport master (
    output mem_req, stallreq_id,
    input  stall, grant_mem, if_done, mem_done, stall_cnt
  );

  modport slave (
    input  mem_req, stallreq_id,
    output stall, grant_mem, if_done, mem_done, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_sram_arb_fsm.sv
// SRAM arbiter between instruction fetch and data access, with wait-state
// sequencing. Every IDLE cycle starts a new access; a MEM access is never
// started right after a MEM access so the fetch side cannot starve.
//
//   state       | meaning
//   ------------+---------------------------------------------------
//   ST_IDLE     | first cycle of an access (cnt=0), owner chosen here
//   ST_BUSY_IF  | fetch access in progress, cnt = elapsed cycles
//   ST_BUSY_MEM | data access in progress, cnt = elapsed cycles
module sram_arb_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic acc_mem,
  output logic acc_final,
  output logic grant_mem,
  output logic if_done,
  output logic mem_done
);

  localparam logic [CNT_W-1:0] WAIT_V = CNT_W'(WAIT_CYCLES);

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             last_mem;

  // Owner and final-cycle flag of the access in flight this cycle.
  always_comb begin
    acc_mem   = 1'b0;
    acc_final = 1'b0;
    case (state)
      ST_IDLE: begin
        acc_mem   = mem_req & ~last_mem;
        acc_final = (WAIT_CYCLES == 0);
      end
      ST_BUSY_IF: begin
        acc_mem   = 1'b0;
        acc_final = (cnt == WAIT_V);
      end
      ST_BUSY_MEM: begin
        acc_mem   = 1'b1;
        acc_final = (cnt == WAIT_V);
      end
      default: begin
        acc_mem   = 1'b0;
        acc_final = 1'b0;
      end
    endcase
  end

  // Status outputs follow the current access and are forced low in reset.
  always_comb begin
    grant_mem = ~rst & acc_mem;
    if_done   = ~rst & ~acc_mem & acc_final;
    mem_done  = ~rst & acc_mem & acc_final;
  end

  // State, elapsed-cycle counter and last-owner memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last_mem <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (WAIT_CYCLES == 0) begin
            last_mem <= acc_mem;
          end else begin
            state <= acc_mem ? ST_BUSY_MEM : ST_BUSY_IF;
            cnt   <= CNT_W'(1);
          end
        end
        ST_BUSY_IF, ST_BUSY_MEM: begin
          if (cnt == WAIT_V) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last_mem <= (state == ST_BUSY_MEM);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall controller for the 5-stage pipeline: SRAM arbitration plus
// the stall vector fed to every pipeline register.
// Optional feature: define PIPE_CTRL_STALL_CNT_EN to build a saturating
// counter of stalled-PC cycles on stall_cnt; otherwise stall_cnt reads 0.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  logic       acc_mem;
  logic       acc_final;
  logic [4:0] stall;

  sram_arb_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (bus.mem_req),
    .acc_mem   (acc_mem),
    .acc_final (acc_final),
    .grant_mem (bus.grant_mem),
    .if_done   (bus.if_done),
    .mem_done  (bus.mem_done)
  );

  // Stall encoder; a MEM wait freezes everything up to ex_mem, otherwise
  // the PC holds until a fetch completes and ID can add its load-use hold.
  always_comb begin
    stall = StallNone;
    if (rst) begin
      stall = StallNone;
    end else if (acc_mem && !acc_final) begin
      stall = StallMemWait;
    end else if (acc_mem || !acc_final) begin
      stall = bus.stallreq_id ? StallId : StallIf;
    end else begin
      stall = bus.stallreq_id ? StallId : StallNone;
    end
  end

  assign bus.stall = stall;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall[STALL_PC] == StallYes && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = rst ? 16'h0000 : stall_cnt;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl across WAIT_CYCLES = 0..3. Inputs change on
// the falling edge; outputs are sampled 1 time unit later.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_ctrl_if i0 ();
  pipe_ctrl_if i1 ();
  pipe_ctrl_if i2 ();
  pipe_ctrl_if i3 ();

  pipe_ctrl #(.WAIT_CYCLES(0), .CNT_W(3)) u0 (.clk(clk), .rst(rst), .bus(i0));
  pipe_ctrl #(.WAIT_CYCLES(1), .CNT_W(3)) u1 (.clk(clk), .rst(rst), .bus(i1));
  pipe_ctrl #(.WAIT_CYCLES(2), .CNT_W(3)) u2 (.clk(clk), .rst(rst), .bus(i2));
  pipe_ctrl #(.WAIT_CYCLES(3), .CNT_W(3)) u3 (.clk(clk), .rst(rst), .bus(i3));

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int idx, input logic mreq, input logic sreq, input logic r,
                      input logic [4:0] e_stall, input logic e_grant,
                      input logic e_ifd, input logic e_memd, input string tag);
    logic [4:0]  o_stall;
    logic        o_grant, o_ifd, o_memd;
    logic [15:0] o_cnt;
    logic [15:0] e_cnt;
    @(negedge clk);
    rst = r;
    i0.mem_req = 1'b0; i0.stallreq_id = 1'b0;
    i1.mem_req = 1'b0; i1.stallreq_id = 1'b0;
    i2.mem_req = 1'b0; i2.stallreq_id = 1'b0;
    i3.mem_req = 1'b0; i3.stallreq_id = 1'b0;
    case (idx)
      0: begin i0.mem_req = mreq; i0.stallreq_id = sreq; end
      1: begin i1.mem_req = mreq; i1.stallreq_id = sreq; end
      2: begin i2.mem_req = mreq; i2.stallreq_id = sreq; end
      default: begin i3.mem_req = mreq; i3.stallreq_id = sreq; end
    endcase
    #1;
    case (idx)
      0: begin o_stall = i0.stall; o_grant = i0.grant_mem; o_ifd = i0.if_done; o_memd = i0.mem_done; o_cnt = i0.stall_cnt; end
      1: begin o_stall = i1.stall; o_grant = i1.grant_mem; o_ifd = i1.if_done; o_memd = i1.mem_done; o_cnt = i1.stall_cnt; end
      2: begin o_stall = i2.stall; o_grant = i2.grant_mem; o_ifd = i2.if_done; o_memd = i2.mem_done; o_cnt = i2.stall_cnt; end
      default: begin o_stall = i3.stall; o_grant = i3.grant_mem; o_ifd = i3.if_done; o_memd = i3.mem_done; o_cnt = i3.stall_cnt; end
    endcase
`ifdef PIPE_CTRL_STALL_CNT_EN
    e_cnt = r ? 16'h0000 : 16'(exp_cnt);
`else
    e_cnt = 16'h0000;
`endif
    chk({tag, ".stall"},     16'(o_stall), 16'(e_stall));
    chk({tag, ".grant_mem"}, 16'(o_grant), 16'(e_grant));
    chk({tag, ".if_done"},   16'(o_ifd),   16'(e_ifd));
    chk({tag, ".mem_done"},  16'(o_memd),  16'(e_memd));
    chk({tag, ".stall_cnt"}, o_cnt,        e_cnt);
    if (r) exp_cnt = 0;
    else   exp_cnt = exp_cnt + int'(e_stall[0]);
  endtask

  initial begin
    // WAIT_CYCLES=0: reset, transparent fetch, single and held MEM requests
    step(0, 0, 0, 1, 5'b00000, 0, 0, 0, "w0_rst_a");
    step(0, 0, 0, 1, 5'b00000, 0, 0, 0, "w0_rst_b");
    step(0, 0, 0, 0, 5'b00000, 0, 1, 0, "w0_idle_a");
    step(0, 0, 0, 0, 5'b00000, 0, 1, 0, "w0_idle_b");
    step(0, 0, 0, 0, 5'b00000, 0, 1, 0, "w0_idle_c");
    step(0, 1, 0, 0, 5'b00001, 1, 0, 1, "w0_mem");
    step(0, 0, 0, 0, 5'b00000, 0, 1, 0, "w0_if_after");
    step(0, 1, 0, 0, 5'b00001, 1, 0, 1, "w0_mem_b2b_a");
    step(0, 1, 0, 0, 5'b00000, 0, 1, 0, "w0_alt_if");
    step(0, 1, 0, 0, 5'b00001, 1, 0, 1, "w0_mem_b2b_b");
    step(0, 0, 1, 0, 5'b00011, 0, 1, 0, "w0_if_fin_id");
    step(0, 1, 1, 0, 5'b00011, 1, 0, 1, "w0_mem_fin_id");

    // WAIT_CYCLES=2: IF access, single load, back-to-back alternation
    step(2, 0, 0, 1, 5'b00000, 0, 0, 0, "w2_rst_a");
    step(2, 0, 0, 1, 5'b00000, 0, 0, 0, "w2_rst_b");
    step(2, 0, 0, 0, 5'b00001, 0, 0, 0, "w2_if_c0");
    step(2, 0, 0, 0, 5'b00001, 0, 0, 0, "w2_if_c1");
    step(2, 0, 0, 0, 5'b00000, 0, 1, 0, "w2_if_c2");
    step(2, 1, 0, 0, 5'b01111, 1, 0, 0, "w2_mem_c0");
    step(2, 1, 0, 0, 5'b01111, 1, 0, 0, "w2_mem_c1");
    step(2, 1, 0, 0, 5'b00001, 1, 0, 1, "w2_mem_c2");
    step(2, 1, 0, 0, 5'b00001, 0, 0, 0, "w2_alt_if_c0");
    step(2, 1, 0, 0, 5'b00001, 0, 0, 0, "w2_alt_if_c1");
    step(2, 1, 0, 0, 5'b00000, 0, 1, 0, "w2_alt_if_c2");
    step(2, 1, 0, 0, 5'b01111, 1, 0, 0, "w2_mem2_c0");
    step(2, 1, 0, 0, 5'b01111, 1, 0, 0, "w2_mem2_c1");
    step(2, 1, 0, 0, 5'b00001, 1, 0, 1, "w2_mem2_c2");
    step(2, 0, 0, 0, 5'b00001, 0, 0, 0, "w2_if_next");

    // WAIT_CYCLES=1: mem_req arrives mid-fetch, no preemption, ID hold on finals
    step(1, 0, 0, 1, 5'b00000, 0, 0, 0, "w1_rst_a");
    step(1, 0, 0, 1, 5'b00000, 0, 0, 0, "w1_rst_b");
    step(1, 0, 0, 0, 5'b00001, 0, 0, 0, "w1_if_c0");
    step(1, 1, 1, 0, 5'b00011, 0, 1, 0, "w1_if_c1_id");
    step(1, 1, 0, 0, 5'b01111, 1, 0, 0, "w1_mem_c0");
    step(1, 1, 1, 0, 5'b00011, 1, 0, 1, "w1_mem_c1_id");
    step(1, 0, 0, 0, 5'b00001, 0, 0, 0, "w1_if_next");

    // WAIT_CYCLES=3: reset in the middle of a MEM access
    step(3, 0, 0, 1, 5'b00000, 0, 0, 0, "w3_rst_a");
    step(3, 0, 0, 1, 5'b00000, 0, 0, 0, "w3_rst_b");
    step(3, 1, 0, 0, 5'b01111, 1, 0, 0, "w3_mem_c0");
    step(3, 1, 0, 0, 5'b01111, 1, 0, 0, "w3_mem_c1");
    step(3, 1, 0, 1, 5'b00000, 0, 0, 0, "w3_rst_mid");
    step(3, 0, 0, 0, 5'b00001, 0, 0, 0, "w3_if_c0");
    step(3, 0, 0, 0, 5'b00001, 0, 0, 0, "w3_if_c1");
    step(3, 0, 0, 0, 5'b00001, 0, 0, 0, "w3_if_c2");
    step(3, 0, 0, 0, 5'b00000, 0, 1, 0, "w3_if_c3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
